// File: rtl/snn_pkg.sv
// Shared types and helpers for the SNN inference controller: FSM state encoding,
// default widths, and the saturating counter increment.
package snn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_RUN    = 3'd2,
        ST_DECIDE = 3'd3,
        ST_DONE   = 3'd4
    } snn_state_e;

    localparam int SNN_NUM_OUT = 2;
    localparam int SNN_IN_W    = 8;
    localparam int SNN_CNT_W   = 8;
    localparam int SNN_STEP_W  = 8;

    // Increment v, clamping at 2^w-1 so a counter of width w never wraps.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] lim;
        if (w >= 32'd32) begin
            lim = 32'hFFFF_FFFF;
        end else begin
            lim = (32'd1 << w) - 32'd1;
        end
        if (v >= lim) begin
            return lim;
        end else begin
            return v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/snn_inference_ctrl_if.sv
// Host/core-facing signal bundle of the inference controller. The master side is the
// host plus SNN core; the slave side is the controller itself.
interface snn_inference_ctrl_if #(
    parameter int NUM_OUT = 2,
    parameter int IN_W    = 8,
    parameter int CNT_W   = 8,
    parameter int STEP_W  = 8
);
    localparam int WIN_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

    logic               start;
    logic               abort;
    logic [IN_W-1:0]    input_value;
    logic [STEP_W-1:0]  num_steps;
    logic [NUM_OUT-1:0] snn_spikes;
    logic               snn_clear;
    logic [IN_W-1:0]    snn_input;
    logic               busy;
    logic               done;
    logic [WIN_W-1:0]   winner;
    logic [CNT_W-1:0]   max_count;
    logic               tie;

    modport master (
        output start, abort, input_value, num_steps, snn_spikes,
        input  snn_clear, snn_input, busy, done, winner, max_count, tie
    );

    modport slave (
        input  start, abort, input_value, num_steps, snn_spikes,
        output snn_clear, snn_input, busy, done, winner, max_count, tie
    );
endinterface

// File: rtl/snn_argmax.sv
// Combinational argmax over the per-class spike counters; equal counts resolve to the
// lowest index, and tie flags any other class matching the maximum.
module snn_argmax #(
    parameter int NUM_OUT = 2,
    parameter int CNT_W   = 8,
    parameter int WIN_W   = 1
) (
    input  logic [NUM_OUT-1:0][CNT_W-1:0] counts_i,
    output logic [WIN_W-1:0]              winner_o,
    output logic [CNT_W-1:0]              max_o,
    output logic                          tie_o
);

    // Strict greater-than keeps the earliest index on equal counts.
    always_comb begin
        winner_o = {WIN_W{1'b0}};
        max_o    = counts_i[0];
        tie_o    = 1'b0;
        for (int i = 1; i < NUM_OUT; i++) begin
            if (counts_i[i] > max_o) begin
                max_o    = counts_i[i];
                winner_o = WIN_W'(i);
            end else begin
                max_o    = max_o;
            end
        end
        for (int i = 0; i < NUM_OUT; i++) begin
            if ((WIN_W'(i) != winner_o) && (counts_i[i] == max_o)) begin
                tie_o = 1'b1;
            end else begin
                tie_o = tie_o;
            end
        end
    end

endmodule

// File: rtl/snn_inference_ctrl.sv
// Sequences one SNN inference: clear the core, run a fixed number of time steps while
// counting output spikes per class, then publish the winning class with a done pulse.
module snn_inference_ctrl
    import snn_pkg::*;
#(
    parameter int NUM_OUT      = SNN_NUM_OUT,
    parameter int IN_W         = SNN_IN_W,
    parameter int CNT_W        = SNN_CNT_W,
    parameter int STEP_W       = SNN_STEP_W,
    parameter int CLEAR_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    snn_inference_ctrl_if.slave  ctrl_if
);

    localparam int WIN_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    snn_state_e                   state_q, state_d;
    logic [CLR_W-1:0]             clr_cnt_q, clr_cnt_d;
    logic [STEP_W-1:0]            step_q, step_d;
    logic [IN_W-1:0]              input_q, input_d;
    logic [NUM_OUT-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [WIN_W-1:0]             winner_q, winner_d;
    logic [CNT_W-1:0]             max_q, max_d;
    logic                         tie_q, tie_d;
    logic                         snn_clear_q, snn_clear_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;

    logic [WIN_W-1:0]             am_winner_s;
    logic [CNT_W-1:0]             am_max_s;
    logic                         am_tie_s;
    logic                         accept_s;
    logic                         abort_s;

    assign accept_s = (state_q == ST_IDLE) && ctrl_if.start;
    assign abort_s  = (state_q != ST_IDLE) && ctrl_if.abort;

    snn_argmax #(
        .NUM_OUT (NUM_OUT),
        .CNT_W   (CNT_W),
        .WIN_W   (WIN_W)
    ) u_argmax (
        .counts_i (cnt_q),
        .winner_o (am_winner_s),
        .max_o    (am_max_s),
        .tie_o    (am_tie_s)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            clr_cnt_q   <= {CLR_W{1'b0}};
            step_q      <= {STEP_W{1'b0}};
            input_q     <= {IN_W{1'b0}};
            cnt_q       <= {(NUM_OUT*CNT_W){1'b0}};
            winner_q    <= {WIN_W{1'b0}};
            max_q       <= {CNT_W{1'b0}};
            tie_q       <= 1'b0;
            snn_clear_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            step_q      <= step_d;
            input_q     <= input_d;
            cnt_q       <= cnt_d;
            winner_q    <= winner_d;
            max_q       <= max_d;
            tie_q       <= tie_d;
            snn_clear_q <= snn_clear_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Next-state selection; abort overrides every other transition outside IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_if.start) begin
                    state_d = ST_CLEAR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q != {CLR_W{1'b0}}) begin
                    state_d = ST_CLEAR;
                end else if (step_q == {STEP_W{1'b0}}) begin
                    state_d = ST_DECIDE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (step_q <= STEP_W'(1)) begin
                    state_d = ST_DECIDE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DECIDE: state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (abort_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_d;
        end
    end

    // Counters, latched operands and result capture.
    always_comb begin
        clr_cnt_d = clr_cnt_q;
        step_d    = step_q;
        input_d   = input_q;
        cnt_d     = cnt_q;
        winner_d  = winner_q;
        max_d     = max_q;
        tie_d     = tie_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    clr_cnt_d = CLR_W'(CLEAR_CYCLES - 1);
                    step_d    = ctrl_if.num_steps;
                    input_d   = ctrl_if.input_value;
                    cnt_d     = {(NUM_OUT*CNT_W){1'b0}};
                end else begin
                    cnt_d     = cnt_q;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q != {CLR_W{1'b0}}) begin
                    clr_cnt_d = clr_cnt_q - CLR_W'(1);
                end else begin
                    clr_cnt_d = clr_cnt_q;
                end
            end
            ST_RUN: begin
                step_d = step_q - STEP_W'(1);
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (ctrl_if.snn_spikes[i]) begin
                        cnt_d[i] = CNT_W'(sat_inc(32'(cnt_q[i]), CNT_W));
                    end else begin
                        cnt_d[i] = cnt_q[i];
                    end
                end
            end
            ST_DECIDE: begin
                if (!abort_s) begin
                    winner_d = am_winner_s;
                    max_d    = am_max_s;
                    tie_d    = am_tie_s;
                end else begin
                    winner_d = winner_q;
                end
            end
            ST_DONE: step_d = step_q;
            default: step_d = step_q;
        endcase
    end

    // Outputs are derived from the next state so they register in step with it.
    always_comb begin
        snn_clear_d = (state_d != ST_RUN);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    assign ctrl_if.snn_clear = snn_clear_q;
    assign ctrl_if.snn_input = input_q;
    assign ctrl_if.busy      = busy_q;
    assign ctrl_if.done      = done_q;
    assign ctrl_if.winner    = winner_q;
    assign ctrl_if.max_count = max_q;
    assign ctrl_if.tie       = tie_q;

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Directed bench for snn_inference_ctrl: a CNT_W=8 instance for most scenarios and a
// CNT_W=4 instance for the narrow-counter saturation run.
module tb_snn_inference_ctrl;
    localparam int C = 2;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    snn_inference_ctrl_if #(.NUM_OUT(2), .IN_W(8), .CNT_W(8), .STEP_W(8)) m ();
    snn_inference_ctrl_if #(.NUM_OUT(2), .IN_W(8), .CNT_W(4), .STEP_W(8)) n ();

    snn_inference_ctrl #(.NUM_OUT(2), .IN_W(8), .CNT_W(8), .STEP_W(8), .CLEAR_CYCLES(C)) dut (
        .clk(clk), .rst_n(rst_n), .ctrl_if(m)
    );
    snn_inference_ctrl #(.NUM_OUT(2), .IN_W(8), .CNT_W(4), .STEP_W(8), .CLEAR_CYCLES(C)) dut4 (
        .clk(clk), .rst_n(rst_n), .ctrl_if(n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] spk(input int mode, input int r);
        case (mode)
            0:       return 2'b01;
            1:       return (r < 5) ? 2'b10 : 2'b01;
            2:       return (r < 4) ? 2'b01 : 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    // One inference on the main instance; lat = cycles after the accepting edge until done.
    task automatic run_main(input logic [7:0] val, input logic [7:0] steps, input int mode,
                            input bit abort_with_start, output int lat, output bit clr_ok,
                            output logic [7:0] in1);
        lat = -1; clr_ok = 1'b1; in1 = 8'h00;
        @(posedge clk); #1;
        m.input_value = val; m.num_steps = steps; m.start = 1'b1;
        m.abort = abort_with_start; m.snn_spikes = 2'b00;
        @(posedge clk); #1;
        m.start = 1'b0; m.abort = 1'b0; m.input_value = ~val; m.num_steps = steps + 8'd3;
        for (int j = 1; j <= 400; j++) begin
            if (j == 1) in1 = m.snn_input;
            if (m.snn_clear !== !((j >= C + 1) && (j <= C + int'(steps)))) clr_ok = 1'b0;
            if (m.done === 1'b1) begin
                lat = j;
                break;
            end
            if ((j >= C + 1) && (j <= C + int'(steps))) m.snn_spikes = spk(mode, j - C - 1);
            else m.snn_spikes = 2'b00;
            @(posedge clk); #1;
        end
        m.snn_spikes = 2'b00;
    endtask

    task automatic test_reset();
        checks++;
        if ({m.snn_clear, m.snn_input, m.busy, m.done, m.winner, m.max_count, m.tie} !== {1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset: got clear=%b in=%h busy=%b done=%b win=%b max=%0d tie=%b, expected 1 00 0 0 0 0 0",
                     m.snn_clear, m.snn_input, m.busy, m.done, m.winner, m.max_count, m.tie);
        end
    endtask

    task automatic check_result(input string name, input int lat, input int exp_lat,
                                input logic exp_w, input logic [7:0] exp_max, input logic exp_tie);
        checks++;
        if (lat !== exp_lat) begin
            errors++; $display("FAIL %s latency: got %0d, expected %0d", name, lat, exp_lat);
        end
        checks++;
        if ({m.winner, m.max_count, m.tie} !== {exp_w, exp_max, exp_tie}) begin
            errors++;
            $display("FAIL %s result: got win=%b max=%0d tie=%b, expected win=%b max=%0d tie=%b",
                     name, m.winner, m.max_count, m.tie, exp_w, exp_max, exp_tie);
        end
    endtask

    task automatic test_basic();
        int lat; bit clr_ok; logic [7:0] in1;
        run_main(8'h5A, 8'd10, 0, 1'b0, lat, clr_ok, in1);
        check_result("basic", lat, 14, 1'b0, 8'd10, 1'b0);
        checks++;
        if (!clr_ok) begin errors++; $display("FAIL basic snn_clear: got wrong profile, expected high 2 low 10"); end
        checks++;
        if (in1 !== 8'h5A) begin errors++; $display("FAIL basic snn_input: got %h, expected 5a", in1); end
        checks++;
        if (m.snn_input !== 8'h5A) begin errors++; $display("FAIL basic snn_input hold: got %h, expected 5a", m.snn_input); end
    endtask

    task automatic test_class1();
        int lat; bit clr_ok; logic [7:0] in1;
        run_main(8'h11, 8'd8, 1, 1'b0, lat, clr_ok, in1);
        check_result("class1", lat, 12, 1'b1, 8'd5, 1'b0);
    endtask

    task automatic test_tie_zero();
        int lat; bit clr_ok; logic [7:0] in1;
        run_main(8'h22, 8'd8, 2, 1'b0, lat, clr_ok, in1);
        check_result("tie", lat, 12, 1'b0, 8'd4, 1'b1);
        run_main(8'h23, 8'd0, 0, 1'b0, lat, clr_ok, in1);
        check_result("zero_steps", lat, 4, 1'b0, 8'd0, 1'b1);
        checks++;
        if (!clr_ok) begin errors++; $display("FAIL zero_steps snn_clear: got a low cycle, expected always high"); end
    endtask

    task automatic test_saturation();
        int lat; bit clr_ok; logic [7:0] in1;
        run_main(8'h33, 8'd255, 3, 1'b0, lat, clr_ok, in1);
        check_result("sat8", lat, 259, 1'b0, 8'd255, 1'b1);
        lat = -1;
        @(posedge clk); #1;
        n.num_steps = 8'd20; n.input_value = 8'h44; n.start = 1'b1; n.snn_spikes = 2'b11;
        @(posedge clk); #1;
        n.start = 1'b0;
        for (int j = 1; j <= 100; j++) begin
            if (n.done === 1'b1) begin lat = j; break; end
            @(posedge clk); #1;
        end
        n.snn_spikes = 2'b00;
        checks++;
        if (lat !== 24) begin errors++; $display("FAIL sat4 latency: got %0d, expected 24", lat); end
        checks++;
        if ({n.winner, n.max_count, n.tie} !== {1'b0, 4'd15, 1'b1}) begin
            errors++;
            $display("FAIL sat4 result: got win=%b max=%0d tie=%b, expected win=0 max=15 tie=1", n.winner, n.max_count, n.tie);
        end
    endtask

    task automatic test_abort();
        int dones;
        dones = 0;
        @(posedge clk); #1;
        m.input_value = 8'h77; m.num_steps = 8'd10; m.start = 1'b1; m.snn_spikes = 2'b10;
        @(posedge clk); #1;
        m.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        m.abort = 1'b1;
        @(posedge clk); #1;
        m.abort = 1'b0;
        checks++;
        if ({m.busy, m.snn_clear, m.done} !== 3'b010) begin
            errors++; $display("FAIL abort state: got busy=%b clear=%b done=%b, expected 0 1 0", m.busy, m.snn_clear, m.done);
        end
        for (int j = 0; j < 20; j++) begin
            if (m.done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        m.snn_spikes = 2'b00;
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL abort done: got %0d pulses, expected 0", dones); end
        checks++;
        if ({m.winner, m.max_count, m.tie} !== {1'b0, 8'd255, 1'b1}) begin
            errors++; $display("FAIL abort result: got win=%b max=%0d tie=%b, expected 0 255 1", m.winner, m.max_count, m.tie);
        end
    endtask

    task automatic test_start_while_busy();
        int dones;
        dones = 0;
        @(posedge clk); #1;
        m.input_value = 8'h5A; m.num_steps = 8'd10; m.start = 1'b1; m.abort = 1'b1; m.snn_spikes = 2'b01;
        @(posedge clk); #1;
        m.start = 1'b0; m.abort = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        m.start = 1'b1; m.num_steps = 8'd3; m.input_value = 8'h99;
        @(posedge clk); #1;
        m.start = 1'b0;
        for (int j = 0; j < 40; j++) begin
            if (m.done === 1'b1) dones++;
            @(posedge clk); #1;
        end
        m.snn_spikes = 2'b00;
        checks++;
        if (dones !== 1) begin errors++; $display("FAIL busy_start dones: got %0d, expected 1", dones); end
        checks++;
        if ({m.winner, m.max_count, m.tie, m.snn_input} !== {1'b0, 8'd10, 1'b0, 8'h5A}) begin
            errors++;
            $display("FAIL busy_start result: got win=%b max=%0d tie=%b in=%h, expected 0 10 0 5a", m.winner, m.max_count, m.tie, m.snn_input);
        end
    endtask

    task automatic test_async_reset();
        int lat; bit clr_ok; logic [7:0] in1;
        @(posedge clk); #1;
        m.input_value = 8'h66; m.num_steps = 8'd10; m.start = 1'b1; m.snn_spikes = 2'b01;
        @(posedge clk); #1;
        m.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        test_reset();
        #1 rst_n = 1'b1;
        m.snn_spikes = 2'b00;
        run_main(8'h5A, 8'd10, 0, 1'b0, lat, clr_ok, in1);
        check_result("after_reset", lat, 14, 1'b0, 8'd10, 1'b0);
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0;
        m.start = 1'b0; m.abort = 1'b0; m.input_value = 8'h00; m.num_steps = 8'h00; m.snn_spikes = 2'b00;
        n.start = 1'b0; n.abort = 1'b0; n.input_value = 8'h00; n.num_steps = 8'h00; n.snn_spikes = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_class1();
        test_tie_zero();
        test_saturation();
        test_abort();
        test_start_while_busy();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
